// File: rtl/button_conditioner_if.sv
// Button bundle between the pad ring and the conditioner.
// The pad side drives the raw buttons and receives the conditioned pulse and level vectors.
interface button_conditioner_if #(
  parameter int N_BTN = 6
);
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_pulse;
  logic [N_BTN-1:0] btn_level;

  modport master (
    output btn_raw,
    input  btn_pulse,
    input  btn_level
  );

  modport slave (
    input  btn_raw,
    output btn_pulse,
    output btn_level
  );
endinterface

// File: rtl/button_conditioner.sv
// Push-button front end for the traffic controller.
// Each raw pad input passes through a 2-flop synchroniser and then a per-channel debounce FSM.
// Every accepted press produces one single-cycle pulse. Channels selected in REPEAT_MASK
// also auto-repeat while they are held. btn_level follows the debounced state of each button.
module button_conditioner #(
  parameter int          N_BTN               = 6,
  parameter int          DEBOUNCE_CYCLES     = 2_500_000,
  parameter int          REPEAT_DELAY_CYCLES = 62_500_000,
  parameter int          REPEAT_RATE_CYCLES  = 12_500_000,
  parameter logic [N_BTN-1:0] REPEAT_MASK    = 6'b011000
) (
  input  logic                 clk,
  input  logic                 reset,
  button_conditioner_if.slave  btn_if
);

  // One counter width serves all three timing intervals. The extra bit leaves
  // saturation headroom above the largest compare value.
  localparam int MAX_DB_DLY = (DEBOUNCE_CYCLES > REPEAT_DELAY_CYCLES) ?
                              DEBOUNCE_CYCLES : REPEAT_DELAY_CYCLES;
  localparam int MAX_CYC    = (MAX_DB_DLY > REPEAT_RATE_CYCLES) ?
                              MAX_DB_DLY : REPEAT_RATE_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] RATE_LAST = CNT_W'(REPEAT_RATE_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PRESS_DB = 3'd1,
    ST_HELD     = 3'd2,
    ST_REPEAT   = 3'd3,
    ST_REL_DB   = 3'd4
  } state_e;

  logic [N_BTN-1:0] sync1_q;
  logic [N_BTN-1:0] sync2_q;
  // fill_q[1] becomes set once sync2_q holds a real pad sample rather than the reset value.
  // Without this flag, the reset zeros could arm a channel whose button was held through reset.
  logic [1:0]       fill_q;
  logic [N_BTN-1:0] pulse_vec;
  logic [N_BTN-1:0] level_vec;

  // Two-flop synchroniser for every channel, plus the pipeline-fill tracker.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= {N_BTN{1'b0}};
      sync2_q <= {N_BTN{1'b0}};
      fill_q  <= 2'b00;
    end else begin
      sync1_q <= btn_if.btn_raw;
      sync2_q <= sync1_q;
      fill_q  <= {fill_q[0], 1'b1};
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             armed_q;
    logic             armed_d;
    logic             pulse_q;
    logic             pulse_d;
    logic             level_q;
    logic             level_d;
    logic             s;

    assign s       = sync2_q[i];
    // The counter saturates instead of wrapping, so long idle or hold periods never
    // alias back onto a compare value.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_ONE);

    // Next-state, counter and output decode for one channel's debounce/repeat FSM.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_inc;
      pulse_d = 1'b0;
      level_d = level_q;
      armed_d = armed_q | (fill_q[1] & ~s);
      case (state_q)
        ST_IDLE: begin
          if (s && armed_q) begin
            state_d = ST_PRESS_DB;
            cnt_d   = CNT_ZERO;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_PRESS_DB: begin
          if (!s) begin
            state_d = ST_IDLE;
            cnt_d   = CNT_ZERO;
          end else if (cnt_q == DB_LAST) begin
            state_d = ST_HELD;
            cnt_d   = CNT_ZERO;
            pulse_d = 1'b1;
            level_d = 1'b1;
          end else begin
            state_d = ST_PRESS_DB;
          end
        end
        ST_HELD: begin
          if (!s) begin
            state_d = ST_REL_DB;
            cnt_d   = CNT_ZERO;
          end else if (REPEAT_MASK[i] && (cnt_q == DLY_LAST)) begin
            state_d = ST_REPEAT;
            cnt_d   = CNT_ZERO;
            pulse_d = 1'b1;
          end else begin
            state_d = ST_HELD;
          end
        end
        ST_REPEAT: begin
          if (!s) begin
            state_d = ST_REL_DB;
            cnt_d   = CNT_ZERO;
          end else if (cnt_q == RATE_LAST) begin
            state_d = ST_REPEAT;
            cnt_d   = CNT_ZERO;
            pulse_d = 1'b1;
          end else begin
            state_d = ST_REPEAT;
          end
        end
        ST_REL_DB: begin
          if (s) begin
            // A bounce during release returns to HELD and restarts the repeat delay.
            state_d = ST_HELD;
            cnt_d   = CNT_ZERO;
          end else if (cnt_q == DB_LAST) begin
            state_d = ST_IDLE;
            cnt_d   = CNT_ZERO;
            level_d = 1'b0;
          end else begin
            state_d = ST_REL_DB;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
          level_d = 1'b0;
        end
      endcase
    end

    // State, counter, arming and registered output flops for one channel.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q <= ST_IDLE;
        cnt_q   <= CNT_ZERO;
        armed_q <= 1'b0;
        pulse_q <= 1'b0;
        level_q <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        armed_q <= armed_d;
        pulse_q <= pulse_d;
        level_q <= level_d;
      end
    end

    assign pulse_vec[i] = pulse_q;
    assign level_vec[i] = level_q;
  end

  assign btn_if.btn_pulse = pulse_vec;
  assign btn_if.btn_level = level_vec;

endmodule
